// File: rtl/karatsuba_split_97bit.sv
// Karatsuba operand splitter: issues lo/mid/hi GF(2) sub-operand pairs.
// Optional 4-bit job tag on op_tag when KSPLIT_TAG_EN is defined.
module karatsuba_split_97bit #(
    parameter int SUBW = 49
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*SUBW-2:0] a_in,
    input  logic [2*SUBW-2:0] b_in,
    output logic [SUBW-1:0]   op_a,
    output logic [SUBW-1:0]   op_b,
    output logic [1:0]        op_sel,
    output logic              op_valid,
    input  logic              op_ready,
`ifdef KSPLIT_TAG_EN
    output logic [3:0]        op_tag,
`endif
    output logic              op_last
);

    localparam int W = 2*SUBW-1;

    localparam logic [1:0] SEL_LO  = 2'd0;
    localparam logic [1:0] SEL_MID = 2'd1;
    localparam logic [1:0] SEL_HI  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ISS_LO,
        ISS_MID,
        ISS_HI
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    a_d;
    logic [W-1:0]    b_d;

    logic [SUBW-1:0] op_a_d;
    logic [SUBW-1:0] op_b_d;
    logic [1:0]      op_sel_d;
    logic            op_valid_d;
    logic            op_last_d;

    logic            accept;

    function automatic logic [SUBW-1:0] lo_of(input logic [W-1:0] x);
        return x[SUBW-1:0];
    endfunction

    function automatic logic [SUBW-1:0] hi_of(input logic [W-1:0] x);
        return {1'b0, x[W-1:SUBW]};
    endfunction

    function automatic logic [SUBW-1:0] mid_of(input logic [W-1:0] x);
        return lo_of(x) ^ hi_of(x);
    endfunction

    // A new job may enter when idle or when the last pair leaves this cycle.
    assign in_ready = (state_q == IDLE) ||
                      ((state_q == ISS_HI) && op_ready);

    assign accept = in_valid && in_ready;

    // Next-state and next-output selection; outputs hold unless a pair moves.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_a_d     = op_a;
        op_b_d     = op_b;
        op_sel_d   = op_sel;
        op_valid_d = op_valid;
        op_last_d  = op_last;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a_in;
                    b_d        = b_in;
                    op_a_d     = lo_of(a_in);
                    op_b_d     = lo_of(b_in);
                    op_sel_d   = SEL_LO;
                    op_last_d  = 1'b0;
                    op_valid_d = 1'b1;
                    state_d    = ISS_LO;
                end
            end
            ISS_LO: begin
                if (op_ready) begin
                    op_a_d   = mid_of(a_q);
                    op_b_d   = mid_of(b_q);
                    op_sel_d = SEL_MID;
                    state_d  = ISS_MID;
                end
            end
            ISS_MID: begin
                if (op_ready) begin
                    op_a_d    = hi_of(a_q);
                    op_b_d    = hi_of(b_q);
                    op_sel_d  = SEL_HI;
                    op_last_d = 1'b1;
                    state_d   = ISS_HI;
                end
            end
            ISS_HI: begin
                if (op_ready) begin
                    op_last_d = 1'b0;
                    if (in_valid) begin
                        a_d      = a_in;
                        b_d      = b_in;
                        op_a_d   = lo_of(a_in);
                        op_b_d   = lo_of(b_in);
                        op_sel_d = SEL_LO;
                        state_d  = ISS_LO;
                    end else begin
                        op_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                op_valid_d = 1'b0;
                op_last_d  = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured operands and registered sub-multiplier outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_sel   <= SEL_LO;
            op_valid <= 1'b0;
            op_last  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_a     <= op_a_d;
            op_b     <= op_b_d;
            op_sel   <= op_sel_d;
            op_valid <= op_valid_d;
            op_last  <= op_last_d;
        end
    end

`ifdef KSPLIT_TAG_EN
    logic [3:0] tag_cnt;

    // Job counter; the tag is latched at acceptance so all pairs share it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt <= 4'd0;
            op_tag  <= 4'd0;
        end else if (accept) begin
            op_tag  <= tag_cnt;
            tag_cnt <= tag_cnt + 4'd1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_karatsuba_split_97bit.sv
// Self-checking bench for karatsuba_split_97bit (scoreboard of expected pairs).
// Define KSPLIT_TAG_EN on both files to check op_tag as well.
module tb_karatsuba_split_97bit;

    localparam int SUBW = 49;
    localparam int W    = 2*SUBW-1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a_in;
    logic [W-1:0]    b_in;
    logic [SUBW-1:0] op_a;
    logic [SUBW-1:0] op_b;
    logic [1:0]      op_sel;
    logic            op_valid;
    logic            op_ready;
    logic            op_last;
`ifdef KSPLIT_TAG_EN
    logic [3:0]      op_tag;
`endif

    always #5 clk = ~clk;

    karatsuba_split_97bit #(.SUBW(SUBW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_sel   (op_sel),
        .op_valid (op_valid),
        .op_ready (op_ready),
`ifdef KSPLIT_TAG_EN
        .op_tag   (op_tag),
`endif
        .op_last  (op_last)
    );

    typedef struct packed {
        logic [SUBW-1:0] a;
        logic [SUBW-1:0] b;
        logic [1:0]      sel;
        logic            last;
        logic [3:0]      tag;
    } pair_t;

    pair_t      exp_q[$];
    logic [3:0] tag_m;
    int         n_cmp;
    int         n_bad;

    function automatic void push_pair(logic [SUBW-1:0] a, logic [SUBW-1:0] b,
                                      logic [1:0] sel, logic last);
        pair_t p;
        p.a    = a;
        p.b    = b;
        p.sel  = sel;
        p.last = last;
`ifdef KSPLIT_TAG_EN
        p.tag  = tag_m;
`else
        p.tag  = 4'd0;
`endif
        exp_q.push_back(p);
    endfunction

    function automatic void push_job(logic [W-1:0] a, logic [W-1:0] b);
        logic [SUBW-1:0] la, lb, ha, hb;
        la = a[SUBW-1:0];
        lb = b[SUBW-1:0];
        ha = {1'b0, a[W-1:SUBW]};
        hb = {1'b0, b[W-1:SUBW]};
        push_pair(la, lb, 2'd0, 1'b0);
        push_pair(la ^ ha, lb ^ hb, 2'd1, 1'b0);
        push_pair(ha, hb, 2'd2, 1'b1);
        tag_m = tag_m + 4'd1;
    endfunction

    function automatic pair_t cur_obs();
        pair_t p;
        p.a    = op_a;
        p.b    = op_b;
        p.sel  = op_sel;
        p.last = op_last;
`ifdef KSPLIT_TAG_EN
        p.tag  = op_tag;
`else
        p.tag  = 4'd0;
`endif
        return p;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic test_reset();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        op_ready = 1'b0;
        a_in     = '0;
        b_in     = '0;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({op_valid, op_a, op_b, op_sel, op_last} !== '0) begin
            n_bad++;
            $display("FAIL reset_outs: got v=%b a=%h b=%h sel=%0d last=%b want all 0",
                     op_valid, op_a, op_b, op_sel, op_last);
        end
`ifdef KSPLIT_TAG_EN
        n_cmp++;
        if (op_tag !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_tag: got %0d want 0", op_tag);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (op_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_valid: got %b want 0", op_valid);
        end
        tag_m = 4'd0;
        exp_q.delete();
    endtask

    task automatic test_basic();
        pair_t e;
        push_pair(49'd1, 49'd1, 2'd0, 1'b0);
        push_pair(49'd1, 49'd1, 2'd1, 1'b0);
        push_pair(49'd0, 49'd0, 2'd2, 1'b1);
        tag_m = tag_m + 4'd1;
        @(posedge clk);
        #1;
        a_in     = 97'd1;
        b_in     = 97'd1;
        in_valid = 1'b1;
        op_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (op_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL basic_valid[%0d]: got %b want 1", i, op_valid);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (cur_obs() !== e) begin
                n_bad++;
                $display("FAIL basic_pair[%0d]: got %h want %h", i, cur_obs(), e);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (op_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_idle: got v=%b rdy=%b want v=0 rdy=1",
                     op_valid, in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0]    va[2];
        logic [W-1:0]    vb[2];
        logic [SUBW-1:0] ones;
        pair_t           e;
        ones  = '1;
        va[0] = 97'd1 << 49;
        vb[0] = 97'd1 << 96;
        va[1] = '1;
        vb[1] = '1;
        op_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            if (v == 0) begin
                push_pair(49'd0, 49'd0, 2'd0, 1'b0);
                push_pair(49'd1, 49'd1 << 47, 2'd1, 1'b0);
                push_pair(49'd1, 49'd1 << 47, 2'd2, 1'b1);
            end else begin
                push_pair(ones, ones, 2'd0, 1'b0);
                push_pair(49'd1 << 48, 49'd1 << 48, 2'd1, 1'b0);
                push_pair(ones >> 1, ones >> 1, 2'd2, 1'b1);
            end
            tag_m = tag_m + 4'd1;
            @(posedge clk);
            #1;
            a_in     = va[v];
            b_in     = vb[v];
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                n_cmp++;
                if (op_valid !== 1'b1 || cur_obs() !== e) begin
                    n_bad++;
                    $display("FAIL vec%0d_pair%0d: got v=%b %h want %h",
                             v, i, op_valid, cur_obs(), e);
                end
            end
        end
    endtask

    task automatic test_stall();
        pair_t e;
        logic [W-1:0] a0, b0;
        a0 = rand_w();
        b0 = rand_w();
        push_job(a0, b0);
        @(posedge clk);
        #1;
        a_in     = a0;
        b_in     = b0;
        in_valid = 1'b1;
        op_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (cur_obs() !== e) begin
            n_bad++;
            $display("FAIL stall_lo: got %h want %h", cur_obs(), e);
        end
        @(posedge clk);
        #1 op_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_in = rand_w();
            b_in = rand_w();
            @(negedge clk);
            n_cmp++;
            if (op_valid !== 1'b1 || op_sel !== 2'd1 || cur_obs() !== exp_q[0]) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got v=%b %h want %h",
                         i, op_valid, cur_obs(), exp_q[0]);
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready);
            end
        end
        @(posedge clk);
        #1 op_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (op_valid !== 1'b1 || cur_obs() !== e) begin
                n_bad++;
                $display("FAIL stall_resume[%0d]: got v=%b %h want %h",
                         i, op_valid, cur_obs(), e);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (op_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_done: got %b want 0", op_valid);
        end
    endtask

    task automatic test_back_to_back();
        pair_t e;
        logic [W-1:0] a0, b0, a1, b1;
        a0 = rand_w();
        b0 = rand_w();
        a1 = rand_w();
        b1 = rand_w();
        push_job(a0, b0);
        push_job(a1, b1);
        @(posedge clk);
        #1;
        a_in     = a0;
        b_in     = b0;
        in_valid = 1'b1;
        op_ready = 1'b1;
        @(posedge clk);
        #1;
        a_in = a1;
        b_in = b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (op_valid !== 1'b1 || cur_obs() !== e) begin
                n_bad++;
                $display("FAIL b2b_pair[%0d]: got v=%b %h want %h",
                         i, op_valid, cur_obs(), e);
            end
            if (i == 2) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_in_ready: got %b want 1", in_ready);
                end
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (op_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done: got %b want 0", op_valid);
        end
    endtask

    task automatic test_reset_mid();
        pair_t e;
        logic [W-1:0] a0, b0;
        a0 = rand_w();
        b0 = rand_w();
        push_job(a0, b0);
        @(posedge clk);
        #1;
        a_in     = a0;
        b_in     = b0;
        in_valid = 1'b1;
        op_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (cur_obs() !== e) begin
            n_bad++;
            $display("FAIL rmid_lo: got %h want %h", cur_obs(), e);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (op_valid !== 1'b0 || op_sel !== 2'd0 || op_a !== '0 || op_last !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_async: got v=%b sel=%0d a=%h last=%b want 0",
                     op_valid, op_sel, op_a, op_last);
        end
        exp_q.delete();
        tag_m = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_in_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (op_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rmid_no_resume[%0d]: got v=%b sel=%0d want v=0",
                         i, op_valid, op_sel);
            end
        end
        a0 = rand_w();
        b0 = rand_w();
        push_job(a0, b0);
        @(posedge clk);
        #1;
        a_in     = a0;
        b_in     = b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (op_valid !== 1'b1 || cur_obs() !== e) begin
                n_bad++;
                $display("FAIL rmid_new[%0d]: got v=%b %h want %h",
                         i, op_valid, cur_obs(), e);
            end
        end
    endtask

    task automatic test_random();
        int   jobs;
        int   cycles;
        logic acc;
        jobs     = 0;
        cycles   = 0;
        acc      = 1'b0;
        in_valid = 1'b0;
        while ((jobs < 40 || exp_q.size() > 0) && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (acc) begin
                in_valid = 1'b0;
                acc      = 1'b0;
            end
            if (!in_valid && jobs < 40 && $urandom_range(0, 2) != 0) begin
                a_in     = rand_w();
                b_in     = rand_w();
                in_valid = 1'b1;
            end
            op_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_cmp++;
            if (op_last !== (op_valid && op_sel == 2'd2)) begin
                n_bad++;
                $display("FAIL rnd_last: got %b want %b", op_last,
                         op_valid && op_sel == 2'd2);
            end
            if (op_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rnd_extra: got %h want none", cur_obs());
                end else begin
                    if (cur_obs() !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL rnd_pair: got %h want %h",
                                 cur_obs(), exp_q[0]);
                    end
                    if (op_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                push_job(a_in, b_in);
                jobs++;
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0 || jobs != 40) begin
            n_bad++;
            $display("FAIL rnd_drain: got %0d left %0d jobs want 0 left 40 jobs",
                     exp_q.size(), jobs);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tag_m = 4'd0;
        test_reset();
        test_basic();
        test_vectors();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
